// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
// Holds the TX state enum, data width and default bit timing.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_PARITY,
    UART_TX_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarts on clear.
// Ports: clk_in, n_reset, clear (in); tick, cnt_nxt (out).
module uart_baud_gen #(
  parameter  int CLKS_PER_BIT = 868,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk_in,
  input  logic          n_reset,
  input  logic          clear,
  output logic          tick,
  output logic [CW-1:0] cnt_nxt
);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_nxt = cnt_q + CW'(1);
    if (clear || tick) cnt_nxt = '0;
  end

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) cnt_q <= '0;
    else          cnt_q <= cnt_nxt;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX controller driving an external 8-bit ShiftReg.
// Ports: clk_in, n_reset; tx_data/tx_valid/tx_ready handshake;
// busy, tx serial out; sr_din/sr_ld/sr_shift to ShiftReg, sr_so back.
// Build option: UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk_in,
  input  logic                   n_reset,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   busy,
  output logic                   tx,
  output logic [UART_DATA_W-1:0] sr_din,
  output logic                   sr_ld,
  output logic                   sr_shift,
  input  logic                   sr_so
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_tx_state_e         state_q, state_d;
  logic [2:0]             bit_q, bit_d;
  logic                   tx_q, tx_d;
  logic                   ld_q, ld_d;
  logic                   sh_q, sh_d;
  logic [UART_DATA_W-1:0] din_q, din_d;
  logic                   accept, clear, tick;
  logic [CW-1:0]          cnt_nxt;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign tx_ready = (state_q == UART_TX_IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  assign clear    = (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_in (clk_in),
    .n_reset(n_reset),
    .clear  (clear),
    .tick   (tick),
    .cnt_nxt(cnt_nxt)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      UART_TX_IDLE: begin
        if (tx_valid) state_d = UART_TX_START;
      end
      UART_TX_START: begin
        if (tick) state_d = UART_TX_DATA;
      end
      UART_TX_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_TX_PARITY;
`else
            state_d = UART_TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (tick) state_d = UART_TX_STOP;
      end
`endif
      UART_TX_STOP: begin
        if (tick) begin
          if (bit_q == 3'(STOP_BITS - 1)) state_d = UART_TX_IDLE;
          else bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = UART_TX_IDLE;
    endcase
    // Bit/stop counter restarts whenever a new state is entered.
    if (state_d != state_q) bit_d = '0;
  end

  always_comb begin
    din_d = accept ? tx_data : din_q;
    ld_d  = accept;
    // Shift one cycle ahead of the bit boundary so the registered
    // tx samples the next data bit exactly as the period rolls over.
    sh_d  = (state_d == UART_TX_DATA) &&
            (cnt_nxt == CW'(CLKS_PER_BIT - 2));
    tx_d  = 1'b1;
    unique case (state_d)
      UART_TX_START:  tx_d = 1'b0;
      UART_TX_DATA:   tx_d = sr_so;
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: tx_d = par_q;
`endif
      default:        tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign par_d = accept ? ^tx_data : par_q;

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) par_q <= 1'b0;
    else          par_q <= par_d;
  end
`endif

  always_ff @(posedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= UART_TX_IDLE;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ld_q    <= 1'b0;
      sh_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ld_q    <= ld_d;
      sh_q    <= sh_d;
      din_q   <= din_d;
    end
  end

  assign tx       = tx_q;
  assign sr_ld    = ld_q;
  assign sr_shift = sh_q;
  assign sr_din   = din_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural ShiftReg.
// Frame shape follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LEN = NB * CPB;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx;
  logic [7:0] sr_din;
  logic       sr_ld, sr_shift, sr_so;
  logic [7:0] sr_q = 8'h00;

  int n_assert = 0;
  int n_fail = 0;

  logic cap [0:199];
  int ld_n, ld_at, sh_n, sh_prev, sh_bad, rdy_at, bad;
  logic [10:0] fr;
  logic r41;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk_in  (clk),
    .n_reset (n_reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .tx      (tx),
    .sr_din  (sr_din),
    .sr_ld   (sr_ld),
    .sr_shift(sr_shift),
    .sr_so   (sr_so)
  );

  always_ff @(posedge clk) begin
    if (sr_ld)         sr_q <= sr_din;
    else if (sr_shift) sr_q <= {1'b0, sr_q[7:1]};
  end
  assign sr_so = sr_q[0];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dec(input int off);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cap[off + CPB*(i+1) + 2];
    return b;
  endfunction

  // Called at a negedge with the DUT idle; records one frame.
  task automatic send(input logic [7:0] d, input int pulse_at,
                      input logic [7:0] pd);
    ld_n = 0; ld_at = 0; sh_n = 0; sh_prev = 0; sh_bad = 0;
    rdy_at = 0;
    for (int i = 0; i < 200; i++) cap[i] = 1'bx;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k == pulse_at) begin
        tx_valid = 1'b1; tx_data = pd;
      end
      if (k == pulse_at + 1) begin
        tx_valid = 1'b0; tx_data = d;
      end
      cap[k] = tx;
      if (sr_ld) begin ld_n++; ld_at = k; end
      if (sr_shift) begin
        if (sh_n > 0 && k - sh_prev != CPB) sh_bad++;
        sh_n++; sh_prev = k;
      end
      if (tx_ready) begin rdy_at = k; break; end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ld", sr_ld, 0);
    chk("rst_shift", sr_shift, 0);
    chk("rst_din", sr_din, 8'h00);
    n_reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 ||
          sr_ld !== 1'b0 || sr_shift !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    // Single frame 8'hA5
    send(8'hA5, -1, 8'h00);
`ifdef UART_TX_PARITY_EN
    fr = 11'b1_0_10100101_0;
`else
    fr = 11'b1_1_10100101_0;
`endif
    for (int p = 0; p < NB; p++) begin
      chk($sformatf("a5_period%0d", p),
          {cap[CPB*p+1], cap[CPB*p+2], cap[CPB*p+3], cap[CPB*p+4]},
          {4{fr[p]}});
    end
    chk("a5_ld_count", ld_n, 1);
    chk("a5_ld_cycle", ld_at, 1);
    chk("a5_shift_count", sh_n, 8);
    chk("a5_shift_gap", sh_bad, 0);
    chk("a5_ready_at", rdy_at, LEN + 1);
    chk("a5_sr_din", sr_din, 8'hA5);
    chk("a5_idle_tx", tx, 1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, -1, 8'h00);
    chk("p07_data", dec(0), 8'h07);
    chk("p07_parity", cap[CPB*9+2], 1);
    chk("p07_stop", cap[CPB*10+2], 1);
    chk("p07_ready_at", rdy_at, 45);
`endif

    // Back-to-back 00 then FF, valid held high
    for (int i = 0; i < 200; i++) cap[i] = 1'bx;
    r41 = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 1; k <= 2*LEN + 2; k++) begin
      @(negedge clk);
      cap[k] = tx;
      if (k == 1) tx_data = 8'hFF;
      if (k == LEN + 1) r41 = tx_ready;
      if (k == LEN + 2) tx_valid = 1'b0;
    end
    chk("b2b_data0", dec(0), 8'h00);
    chk("b2b_stop0", cap[LEN], 1);
    chk("b2b_idle", cap[LEN+1], 1);
    chk("b2b_ready_gap", r41, 1);
    chk("b2b_start1", cap[LEN+2], 0);
    chk("b2b_start1_end", cap[LEN+5], 0);
    chk("b2b_data1", dec(LEN + 1), 8'hFF);
    chk("b2b_stop1", cap[2*LEN+1], 1);
    chk("b2b_ready_end", tx_ready, 1);
    chk("b2b_sr_din", sr_din, 8'hFF);

    // Pulse during DATA is ignored
    send(8'hC3, 10, 8'h3C);
    chk("ign_data", dec(0), 8'hC3);
    chk("ign_ld_count", ld_n, 1);
    chk("ign_ready_at", rdy_at, LEN + 1);
    chk("ign_sr_din", sr_din, 8'hC3);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || sr_ld !== 1'b0) bad++;
    end
    chk("ign_no_frame", bad, 0);

    // Reset during data bit 3 of 8'h5A
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("rst5a_bit2", tx, 0);
    repeat (4) @(negedge clk);
    chk("rst5a_bit3", tx, 1);
    chk("rst5a_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    chk("rst5a_async_tx", tx, 1);
    chk("rst5a_async_busy", busy, 0);
    chk("rst5a_async_ready", tx_ready, 1);
    chk("rst5a_async_shift", sr_shift, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 ||
          sr_shift !== 1'b0 || sr_ld !== 1'b0) bad++;
    end
    chk("rst5a_no_resume", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
